// File: rtl/mac_block_acc_pkg.sv
// Shared helpers for the block MAC: accumulator width, saturation limits, add-overflow detection.
// Pure functions and constants only; no state.
package mac_pkg;

  localparam int LIMIT_W = 64;

  function automatic int acc_w(input int data_w, input int guard);
    return 2 * data_w + guard;
  endfunction

  // Limits are returned in the low w bits of a LIMIT_W vector; callers slice to w.
  function automatic logic [LIMIT_W-1:0] sat_max(input int w, input bit sgn);
    if (sgn) return (64'd1 << (w - 1)) - 64'd1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [LIMIT_W-1:0] sat_min(input int w, input bit sgn);
    if (sgn) return 64'd1 << (w - 1);
    return 64'd0;
  endfunction

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb,
                                   input logic carry, input bit sgn);
    if (sgn) return (a_msb == b_msb) && (s_msb != a_msb);
    return carry;
  endfunction

endpackage

// File: rtl/mac_block_acc_if.sv
// Operand/result handshake bundle for mac_block_acc; master drives operands and out_ready.
// Widths follow DATA_W and the derived accumulator width.
interface mac_block_acc_if import mac_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int GUARD  = 4
);
  localparam int ACC_W = acc_w(DATA_W, GUARD);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              acc_clr;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  mac_out;
  logic              ovf;

  modport master (
    output in_valid, data1, data2, acc_clr, out_ready,
    input  in_ready, out_valid, mac_out, ovf
  );

  modport slave (
    input  in_valid, data1, data2, acc_clr, out_ready,
    output in_ready, out_valid, mac_out, ovf
  );

endinterface

// File: rtl/mac_block_acc_mult.sv
// Stage-1 registered multiplier with a travelling valid bit; one cycle latency.
// Holds product and valid while i_en is low; i_clr drops the valid regardless of i_en.
module mac_mult_stage #(
  parameter int DATA_W = 8,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic                  i_vld,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_vld,
  output logic [2*DATA_W-1:0]   o_prod
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_prod;
  logic          r_vld;
  logic [PW-1:0] r_prod;

  // Extending to full product width first makes the low PW bits exact for either signedness.
  generate
    if (SIGNED != 0) begin : g_sext
      assign w_a_ext = {{DATA_W{i_a[DATA_W-1]}}, i_a};
      assign w_b_ext = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    end else begin : g_zext
      assign w_a_ext = {{DATA_W{1'b0}}, i_a};
      assign w_b_ext = {{DATA_W{1'b0}}, i_b};
    end
  endgenerate

  assign w_prod = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_vld  <= 1'b0;
      r_prod <= '0;
    end else if (i_clr) begin
      r_vld  <= 1'b0;
    end else if (i_en) begin
      r_vld  <= i_vld;
      r_prod <= w_prod;
    end
  end

  assign o_vld  = r_vld;
  assign o_prod = r_prod;

endmodule

// File: rtl/mac_block_acc.sv
// Block multiply-accumulate: sums BLOCK_LEN products, result visible two cycles after the last accept.
// Whole pipeline freezes and in_ready drops while a result is held with out_ready low.
module mac_block_acc import mac_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int GUARD     = 4,
  parameter int BLOCK_LEN = 16,
  parameter int SIGNED    = 1,
  parameter int SAT       = 1
) (
  input  logic            clk,
  input  logic            aclr_n,
  mac_block_acc_if.slave  bus
);

  localparam int ACC_W = acc_w(DATA_W, GUARD);
  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  localparam logic [LIMIT_W-1:0] MAX_L   = sat_max(ACC_W, SIGNED != 0);
  localparam logic [LIMIT_W-1:0] MIN_L   = sat_min(ACC_W, SIGNED != 0);
  localparam logic [ACC_W-1:0]   ACC_MAX = MAX_L[ACC_W-1:0];
  localparam logic [ACC_W-1:0]   ACC_MIN = MIN_L[ACC_W-1:0];
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  logic             w_advance;
  logic             w_p_vld;
  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W:0]   w_sum_full;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_first;
  logic             w_last;
  logic             w_ovf;
  logic             w_step;
  logic [ACC_W-1:0] w_sat;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_sticky_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  logic [ACC_W-1:0] r_out;
  logic             r_out_vld;
  logic             r_ovf;

  assign w_advance    = !r_out_vld || bus.out_ready;
  assign bus.in_ready = w_advance;

  mac_mult_stage #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk    (clk),
    .aclr_n (aclr_n),
    .i_en   (w_advance),
    .i_clr  (bus.acc_clr),
    .i_vld  (bus.in_valid),
    .i_a    (bus.data1),
    .i_b    (bus.data2),
    .o_vld  (w_p_vld),
    .o_prod (w_prod)
  );

  generate
    if (GUARD == 0) begin : g_noguard
      assign w_prod_ext = w_prod;
    end else if (SIGNED != 0) begin : g_sguard
      assign w_prod_ext = {{GUARD{w_prod[PW-1]}}, w_prod};
    end else begin : g_uguard
      assign w_prod_ext = {{GUARD{1'b0}}, w_prod};
    end
  endgenerate

  assign w_sum_full = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_sum      = w_sum_full[ACC_W-1:0];
  assign w_add_ovf  = add_ovf(r_acc[ACC_W-1], w_prod_ext[ACC_W-1], w_sum[ACC_W-1],
                              w_sum_full[ACC_W], SIGNED != 0);

  // The first sample of a block loads rather than adds, so it can never overflow.
  assign w_first      = (r_cnt == '0);
  assign w_last       = (r_cnt == LAST_CNT);
  assign w_ovf        = !w_first && w_add_ovf;
  assign w_sat        = ((SIGNED != 0) && r_acc[ACC_W-1]) ? ACC_MIN : ACC_MAX;
  assign w_acc_nxt    = w_first ? w_prod_ext : ((w_ovf && (SAT != 0)) ? w_sat : w_sum);
  assign w_sticky_nxt = r_sticky | w_ovf;
  assign w_step       = w_advance && w_p_vld && !bus.acc_clr;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (bus.acc_clr) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else if (w_step) begin
        if (w_last) begin
          r_acc    <= '0;
          r_cnt    <= '0;
          r_sticky <= 1'b0;
        end else begin
          r_acc    <= w_acc_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          r_sticky <= w_sticky_nxt;
        end
      end

      // A completing block may replace a result retiring in the same cycle.
      if (w_step && w_last) begin
        r_out     <= w_acc_nxt;
        r_ovf     <= w_sticky_nxt;
        r_out_vld <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.mac_out   = r_out;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_mac_block_acc.sv
// Scoreboard bench for mac_block_acc across five parameter sets sharing one operand bus.
module tb_mac_block_acc;

  typedef struct {
    int val;
    bit ovf;
    int cyc;
  } exp_t;

  logic       clk;
  logic       aclr_n;
  logic       in_valid;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       acc_clr;
  logic       out_ready;
  int         sel;
  logic       cur_rdy;
  logic       cur_vld;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];
  exp_t qe[$];

  mac_block_acc_if #(.DATA_W(8), .GUARD(4)) if_a ();
  mac_block_acc_if #(.DATA_W(8), .GUARD(0)) if_b ();
  mac_block_acc_if #(.DATA_W(8), .GUARD(0)) if_c ();
  mac_block_acc_if #(.DATA_W(8), .GUARD(4)) if_d ();
  mac_block_acc_if #(.DATA_W(8), .GUARD(4)) if_e ();

  assign if_a.in_valid = in_valid && (sel == 0);
  assign if_b.in_valid = in_valid && (sel == 1);
  assign if_c.in_valid = in_valid && (sel == 2);
  assign if_d.in_valid = in_valid && (sel == 3);
  assign if_e.in_valid = in_valid && (sel == 4);
  assign if_a.acc_clr  = acc_clr && (sel == 0);
  assign if_b.acc_clr  = acc_clr && (sel == 1);
  assign if_c.acc_clr  = acc_clr && (sel == 2);
  assign if_d.acc_clr  = acc_clr && (sel == 3);
  assign if_e.acc_clr  = acc_clr && (sel == 4);
  assign if_a.out_ready = (sel == 0) ? out_ready : 1'b1;
  assign if_b.out_ready = (sel == 1) ? out_ready : 1'b1;
  assign if_c.out_ready = (sel == 2) ? out_ready : 1'b1;
  assign if_d.out_ready = (sel == 3) ? out_ready : 1'b1;
  assign if_e.out_ready = (sel == 4) ? out_ready : 1'b1;
  assign if_a.data1 = data1;  assign if_a.data2 = data2;
  assign if_b.data1 = data1;  assign if_b.data2 = data2;
  assign if_c.data1 = data1;  assign if_c.data2 = data2;
  assign if_d.data1 = data1;  assign if_d.data2 = data2;
  assign if_e.data1 = data1;  assign if_e.data2 = data2;

  mac_block_acc #(.DATA_W(8), .GUARD(4), .BLOCK_LEN(4), .SIGNED(1), .SAT(1))
    u_a (.clk(clk), .aclr_n(aclr_n), .bus(if_a));
  mac_block_acc #(.DATA_W(8), .GUARD(0), .BLOCK_LEN(4), .SIGNED(1), .SAT(1))
    u_b (.clk(clk), .aclr_n(aclr_n), .bus(if_b));
  mac_block_acc #(.DATA_W(8), .GUARD(0), .BLOCK_LEN(4), .SIGNED(1), .SAT(0))
    u_c (.clk(clk), .aclr_n(aclr_n), .bus(if_c));
  mac_block_acc #(.DATA_W(8), .GUARD(4), .BLOCK_LEN(4), .SIGNED(0), .SAT(1))
    u_d (.clk(clk), .aclr_n(aclr_n), .bus(if_d));
  mac_block_acc #(.DATA_W(8), .GUARD(4), .BLOCK_LEN(1), .SIGNED(1), .SAT(1))
    u_e (.clk(clk), .aclr_n(aclr_n), .bus(if_e));

  always_comb begin
    cur_rdy = 1'b0;
    cur_vld = 1'b0;
    case (sel)
      0: begin cur_rdy = if_a.in_ready; cur_vld = if_a.out_valid; end
      1: begin cur_rdy = if_b.in_ready; cur_vld = if_b.out_valid; end
      2: begin cur_rdy = if_c.in_ready; cur_vld = if_c.out_valid; end
      3: begin cur_rdy = if_d.in_ready; cur_vld = if_d.out_valid; end
      default: begin cur_rdy = if_e.in_ready; cur_vld = if_e.out_valid; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic push(input int id, input int val, input bit ovf, input int cyc);
    exp_t e;
    e = '{val, ovf, cyc};
    case (id)
      0: qa.push_back(e);
      1: qb.push_back(e);
      2: qc.push_back(e);
      3: qd.push_back(e);
      default: qe.push_back(e);
    endcase
  endtask

  task automatic check_out(input int id, input int got, input logic got_ovf);
    exp_t e;
    bit   found;
    found = 1'b0;
    case (id)
      0: if (qa.size() > 0) begin e = qa.pop_front(); found = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); found = 1'b1; end
      2: if (qc.size() > 0) begin e = qc.pop_front(); found = 1'b1; end
      3: if (qd.size() > 0) begin e = qd.pop_front(); found = 1'b1; end
      default: if (qe.size() > 0) begin e = qe.pop_front(); found = 1'b1; end
    endcase
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out dut%0d got=%0d ovf=%0d at cyc %0d", id, got, got_ovf, ncyc);
    end else begin
      chk($sformatf("mac_out dut%0d", id), got, e.val);
      chk($sformatf("ovf dut%0d", id), {31'd0, got_ovf}, {31'd0, e.ovf});
      if (e.cyc >= 0) chk($sformatf("latency dut%0d", id), ncyc, e.cyc);
    end
  endtask

  // Monitor: pops and compares on every retired result.
  always @(negedge clk) begin
    if (if_a.out_valid && if_a.out_ready) check_out(0, int'(if_a.mac_out), if_a.ovf);
    if (if_b.out_valid && if_b.out_ready) check_out(1, int'(if_b.mac_out), if_b.ovf);
    if (if_c.out_valid && if_c.out_ready) check_out(2, int'(if_c.mac_out), if_c.ovf);
    if (if_d.out_valid && if_d.out_ready) check_out(3, int'(if_d.mac_out), if_d.ovf);
    if (if_e.out_valid && if_e.out_ready) check_out(4, int'(if_e.mac_out), if_e.ovf);
    ncyc++;
  end

  // Called just after a rising edge; returns once the sample has been accepted.
  task automatic put(input logic [7:0] a, input logic [7:0] b, output int acc_idx);
    int   n;
    logic rdy;
    n        = 0;
    in_valid = 1'b1;
    data1    = a;
    data2    = b;
    do begin
      acc_idx = ncyc;
      @(negedge clk);
      rdy = cur_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout sel=%0d waited=%0d", sel, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic block4(input logic [7:0] a, input logic [7:0] b, output int acc_idx);
    repeat (4) put(a, b, acc_idx);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_vld();
    int k;
    k = 0;
    while (!cur_vld && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!cur_vld) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout sel=%0d got=0 exp=1", sel);
    end
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_out_valid"}, {31'd0, if_a.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, if_a.in_ready}, 32'd1);
    chk({tag, "_mac_out"}, 32'(if_a.mac_out), 32'd0);
    chk({tag, "_ovf"}, {31'd0, if_a.ovf}, 32'd0);
  endtask

  initial begin
    int ia;
    aclr_n    = 1'b0;
    in_valid  = 1'b0;
    data1     = '0;
    data2     = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    sel       = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a("rst");
    @(negedge clk) aclr_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed block, full throughput.
    put(8'd3, 8'd5, ia);
    put(8'hFE, 8'd7, ia);
    put(8'd10, 8'd10, ia);
    put(8'h80, 8'h80, ia);
    push(0, 16485, 1'b0, ia + 2);
    idle(4);

    // Same block held by downstream, next block queued behind it.
    out_ready = 1'b0;
    push(0, 16485, 1'b0, -1);
    push(0, 4, 1'b0, -1);
    fork
      begin
        put(8'd3, 8'd5, ia);
        put(8'hFE, 8'd7, ia);
        put(8'd10, 8'd10, ia);
        put(8'h80, 8'h80, ia);
        block4(8'd1, 8'd1, ia);
      end
      begin
        int k;
        k = 0;
        while (!if_a.out_valid && k < 20) begin
          @(negedge clk);
          k++;
        end
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", {31'd0, if_a.in_ready}, 32'd0);
          chk("stall_mac_out", 32'(if_a.mac_out), 32'd16485);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // No guard bits: saturate versus wrap, then a clean block.
    sel = 1;
    block4(8'h80, 8'h80, ia);
    push(1, 32767, 1'b1, ia + 2);
    block4(8'd1, 8'd1, ia);
    push(1, 4, 1'b0, ia + 2);
    idle(4);
    sel = 2;
    block4(8'h80, 8'h80, ia);
    push(2, 0, 1'b1, ia + 2);
    block4(8'd1, 8'd1, ia);
    push(2, 4, 1'b0, ia + 2);
    idle(4);

    // Abort a partial block.
    sel = 0;
    put(8'd9, 8'd9, ia);
    put(8'd9, 8'd9, ia);
    pulse_clr();
    block4(8'd1, 8'd1, ia);
    push(0, 4, 1'b0, ia + 2);
    idle(4);

    // Abort while a result is pending leaves it untouched.
    out_ready = 1'b0;
    block4(8'd1, 8'd1, ia);
    push(0, 4, 1'b0, -1);
    wait_vld();
    pulse_clr();
    chk("clr_keep_valid", {31'd0, if_a.out_valid}, 32'd1);
    chk("clr_keep_mac_out", 32'(if_a.mac_out), 32'd4);
    out_ready = 1'b1;
    block4(8'd3, 8'd3, ia);
    push(0, 36, 1'b0, ia + 2);
    idle(4);

    // Unsigned full-scale, then single-sample blocks.
    sel = 3;
    block4(8'd255, 8'd255, ia);
    push(3, 260100, 1'b0, ia + 2);
    idle(4);
    sel = 4;
    put(8'd2, 8'd3, ia);
    push(4, 6, 1'b0, ia + 2);
    put(8'd4, 8'd5, ia);
    push(4, 20, 1'b0, ia + 2);
    idle(4);

    // Reset in the middle of a block.
    sel = 0;
    put(8'd7, 8'd7, ia);
    put(8'd7, 8'd7, ia);
    aclr_n = 1'b0;
    #1;
    chk_reset_a("rst_mid_block");
    @(negedge clk) aclr_n = 1'b1;
    @(posedge clk);
    #1;
    block4(8'd1, 8'd1, ia);
    push(0, 4, 1'b0, ia + 2);
    idle(4);

    // Reset while a result is stalled.
    out_ready = 1'b0;
    block4(8'd2, 8'd2, ia);
    wait_vld();
    aclr_n = 1'b0;
    #1;
    chk_reset_a("rst_mid_stall");
    @(negedge clk) aclr_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    block4(8'd1, 8'd2, ia);
    push(0, 8, 1'b0, ia + 2);
    idle(6);

    chk("queues_drained", qa.size() + qb.size() + qc.size() + qd.size() + qe.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mac_block_acc.md
# mac_block_acc

Parametrised, pipelined multiply-accumulate engine. It multiplies two operand streams and accumulates products over fixed-length blocks of BLOCK_LEN samples. It presents each block sum through a valid/ready output handshake, with selectable signed/unsigned arithmetic and saturating or wrapping accumulation. It is the block-oriented successor of the free-running 8x8 MAC and sits between sample sources and downstream filter/correlator logic.

## Interface
- DATA_W, 8, operand width (bits)
- GUARD, 4, accumulator guard bits; ACC_W = 2*DATA_W + GUARD
- BLOCK_LEN, 16, samples per block (>= 1)
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
- SAT, 1, 1 = saturate accumulator at ACC_W limits, 0 = wrap
- clk  in  1  single clock, rising edge
- aclr_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- data1, data2  in  DATA_W  operands
- acc_clr  in  1  synchronous abort of current block
- out_valid  out  1  mac_out holds a finished block sum
- out_ready  in  1  downstream accepts mac_out
- mac_out  out  ACC_W  block sum
- ovf  out  1  overflow/saturation occurred in the reported block

## Operation
- Accept: in_valid && in_ready.
- advance = !out_valid || out_ready. in_ready = advance (combinational). Both pipeline stages hold when !advance.
- Stage 1: product register, width 2*DATA_W, signed or unsigned per SIGNED. Valid bit travels alongside.
- Stage 2: accumulator ACC_W plus sample counter 0..BLOCK_LEN-1.
  - The first sample of a block loads the sign/zero-extended product. Later samples add to the accumulator.
  - On the BLOCK_LEN-th sample, the final sum goes to mac_out. out_valid is set, ovf is set from the block's sticky flag. Accumulator, counter and sticky flag restart for the next block.
- Overflow is detected on each add (signed: operand signs equal and result sign differs; unsigned: carry out).
  - SAT=1: clamp to max/min representable value; sticky = 1.
  - SAT=0: wrap modulo 2^ACC_W; sticky = 1.
- Output: out_valid && out_ready retires the result. out_valid drops unless a new block completes in the same cycle, which is legal when advance is high.
- acc_clr (highest priority after reset) clears stage-1 valid, accumulator, counter and sticky flag.
  - A sample presented in the same cycle is discarded.
  - A pending mac_out/out_valid is untouched.
- Reset values: mac_out 0, out_valid 0, ovf 0, counter 0, accumulator 0, stage valids 0. in_ready therefore reads 1 while aclr_n is low.

## Timing
- Accept in cycle t: product registered at the end of t; accumulated at the end of t+1.
- For the last sample of a block, out_valid and mac_out are visible in cycle t+2.
- Throughput: one sample/cycle while out_valid is low or out_ready is high.
- Stall: with out_valid && !out_ready, in_ready is low and no stage changes. Release resumes with no lost or duplicated samples.
- BLOCK_LEN=1: every accepted sample yields one result two cycles later.
- Reset assertion mid-block or mid-stall clears everything immediately (asynchronous). Deassertion is synchronised by the system; the first accept is possible on the first clk edge after release.

## Structure
- Shared package mac_pkg:
  - ACC_W derivation function
  - signed/unsigned saturation-limit functions (max/min for a width)
  - overflow-detect function
- One sub-module: mac_mult_stage (stage-1 registered multiplier with valid and hold enable, parametrised by DATA_W and SIGNED).
- Top holds the accumulator, counter, output register and handshake.

## Test plan
Defaults unless noted: DATA_W=8, GUARD=4, BLOCK_LEN=4, SIGNED=1, SAT=1.
- Samples (3,5),(-2,7),(10,10),(-128,-128) back-to-back, out_ready=1 -> mac_out=16485, ovf=0, out_valid for one cycle, 2 cycles after the 4th accept.
- Same block, then out_ready=0 for 5 cycles while in_valid stays high -> in_ready=0, mac_out stable. The next block of four (1,1) yields 4 after release, with no sample lost.
- GUARD=0, four (-128,-128):
  - SAT=1 -> mac_out=32767, ovf=1.
  - SAT=0 -> mac_out=0, ovf=1.
  - The next block (1,1)x4 -> 4, ovf=0.
- Two samples (9,9), acc_clr pulse, then four (1,1) -> single result 4. acc_clr during a pending output leaves that output intact.
- SIGNED=0, four (255,255) -> mac_out=260100, ovf=0. BLOCK_LEN=1, stream (2,3),(4,5) -> results 6, 20 on consecutive cycles.
- aclr_n low mid-block and mid-stall -> mac_out=0, out_valid=0, ovf=0, in_ready=1 immediately. After release, a fresh block sums from zero.
